wire_label_mem_mp: RTL and testbench

WIRE_LABEL_MEM_MP -- requirements
Module: wire_label_mem_mp

---
 rtl/wire_label_mem_mp.sv | 257 +++++++++++++++++++++++++
 tb/tb_wire_label_mem_mp.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wire_label_mem_mp.sv
// wire_label_mem_mp: multi-channel wire-label store. C write channels feed a
// small write queue that drains into a two-port synchronous RAM; C read
// channels share the same two RAM ports under round-robin arbitration.
// A per-address written flag is set when a queued write commits to RAM.
// Optional build macro WLMEM_FWD_EN: reads also see data still in the queue.
//
// Handshakes: a write on channel i is accepted when wr_en[i] and wr_ready are
// both high at a rising edge. A read on channel i is accepted when rd_req[i]
// and rd_gnt[i] are both high at a rising edge, and rd_valid[i] is high for
// exactly one cycle afterwards. The requester holds rd_addr[i] until granted.
module wire_label_mem_mp #(
    parameter int S  = 13,
    parameter int K  = 128,
    parameter int C  = 2,
    parameter int QD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [C-1:0]         wr_en,
    input  logic [C*S-1:0]       wr_addr,
    input  logic [C*K-1:0]       wr_data,
    output logic                 wr_ready,
    input  logic [C-1:0]         rd_req,
    input  logic [C*S-1:0]       rd_addr,
    output logic [C-1:0]         rd_gnt,
    output logic [C-1:0]         rd_valid,
    output logic [C*K-1:0]       rd_data,
    output logic [C-1:0]         rd_ready,
    output logic [$clog2(QD):0]  q_level,
    output logic                 overflow
);
    localparam int D  = 2 ** S;
    localparam int LW = $clog2(QD) + 1;
    localparam int PW = (QD > 1) ? $clog2(QD) : 1;
    localparam int RW = (C > 1) ? $clog2(C) : 1;

    logic [K-1:0]  mem [D];
    logic [S-1:0]  q_addr [QD];
    logic [K-1:0]  q_data [QD];
    logic [PW-1:0] head, tail, hp1;
    logic [LW-1:0] level;
    logic [D-1:0]  flags;
    logic [RW-1:0] rr_ptr, g0, g1, ch;
    logic [C-1:0]  gnt, src_b;
    int            lvl_i, pops, max_rd, n_g, n_enq;
    logic          we_a, we_b;
    logic [S-1:0]  addr_a, addr_b;
    logic [K-1:0]  wd_a, wd_b, q_ra, q_rb;
    logic [C-1:0]  rv_r, src_b_r;
    logic [K-1:0]  held [C];
    logic [K-1:0]  rd_new [C];
    logic [PW-1:0] enq_slot [C];

    // Queue has room for a full set of channel writes.
    assign wr_ready = (QD - int'(level)) >= C;
    assign q_level  = level;
    assign rd_gnt   = rst ? '0 : gnt;
    assign rd_valid = rv_r;
    assign hp1      = PW'((int'(head) + 1) % QD);

    // Port budget: normal mode serves reads first, drain mode pops first.
    // On clr the queue is being discarded, so nothing is popped.
    always_comb begin
        lvl_i  = clr ? 0 : int'(level);
        pops   = 0;
        max_rd = 2;
        n_g    = 0;
        gnt    = '0;
        g0     = '0;
        g1     = '0;
        ch     = '0;
        if (lvl_i > QD - C) begin
            pops   = (lvl_i >= 2) ? 2 : lvl_i;
            max_rd = 2 - pops;
        end
        for (int k = 0; k < C; k++) begin
            ch = RW'((int'(rr_ptr) + k) % C);
            if (rd_req[ch] && (n_g < max_rd)) begin
                gnt[ch] = 1'b1;
                if (n_g == 0) g0 = ch;
                else          g1 = ch;
                n_g = n_g + 1;
            end
        end
        if (lvl_i <= QD - C) begin
            pops = ((2 - n_g) < lvl_i) ? (2 - n_g) : lvl_i;
        end
    end

    // Map grants and pops onto RAM ports; the younger pop always uses port B.
    always_comb begin
        we_a   = 1'b0;
        we_b   = 1'b0;
        addr_a = '0;
        addr_b = '0;
        wd_a   = q_data[head];
        wd_b   = q_data[head];
        src_b  = '0;
        if (n_g >= 1) begin
            addr_a = rd_addr[int'(g0)*S +: S];
        end else if (pops >= 1) begin
            we_a   = 1'b1;
            addr_a = q_addr[head];
        end
        if (n_g == 2) begin
            addr_b    = rd_addr[int'(g1)*S +: S];
            src_b[g1] = 1'b1;
        end else if ((n_g == 1) && (pops >= 1)) begin
            we_b   = 1'b1;
            addr_b = q_addr[head];
        end else if ((n_g == 0) && (pops == 2)) begin
            we_b   = 1'b1;
            addr_b = q_addr[hp1];
            wd_b   = q_data[hp1];
        end
    end

    // Slot assignment for accepted writes in ascending channel order.
    always_comb begin
        n_enq = 0;
        for (int i = 0; i < C; i++) begin
            enq_slot[i] = PW'((int'(tail) + n_enq) % QD);
            if (wr_ready && wr_en[i]) n_enq = n_enq + 1;
        end
    end

    // Queue payload storage.
    always_ff @(posedge clk) begin
        for (int i = 0; i < C; i++) begin
            if (wr_ready && wr_en[i] && !clr) begin
                q_addr[enq_slot[i]] <= wr_addr[i*S +: S];
                q_data[enq_slot[i]] <= wr_data[i*K +: K];
            end
        end
    end

    // Queue pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            head     <= '0;
            tail     <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            head  <= PW'((int'(head) + pops) % QD);
            tail  <= PW'((int'(tail) + n_enq) % QD);
            level <= LW'(int'(level) + n_enq - pops);
            if (!wr_ready && (|wr_en)) overflow <= 1'b1;
        end
    end

    // Round-robin pointer moves past the last channel granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           rr_ptr <= '0;
        else if (n_g == 2) rr_ptr <= RW'((int'(g1) + 1) % C);
        else if (n_g == 1) rr_ptr <= RW'((int'(g0) + 1) % C);
    end

    // Written flags follow RAM commits; port B last so the younger pop wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= '0;
        end else if (clr) begin
            flags <= '0;
        end else begin
            if (we_a) flags[addr_a] <= 1'b1;
            if (we_b) flags[addr_b] <= 1'b1;
        end
    end

    // Two-port RAM with registered read data (read-before-write).
    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= wd_a;
        if (we_b) mem[addr_b] <= wd_b;
        q_ra <= mem[addr_a];
        q_rb <= mem[addr_b];
    end

    // Read return tracking and per-channel hold of the last returned data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_r    <= '0;
            src_b_r <= '0;
            for (int i = 0; i < C; i++) held[i] <= '0;
        end else begin
            rv_r    <= gnt;
            src_b_r <= src_b;
            for (int i = 0; i < C; i++) begin
                if (rv_r[i]) held[i] <= rd_new[i];
            end
        end
    end

`ifdef WLMEM_FWD_EN
    logic [C-1:0] fwd_hit, fwd_hit_r;
    logic [K-1:0] fwd_data [C];
    logic [K-1:0] fwd_data_r [C];

    // Youngest queued entry matching each channel's read address.
    always_comb begin
        for (int i = 0; i < C; i++) begin
            fwd_hit[i]  = 1'b0;
            fwd_data[i] = '0;
            for (int k = 0; k < QD; k++) begin
                if ((k < int'(level)) &&
                    (q_addr[PW'((int'(head) + k) % QD)] == rd_addr[i*S +: S])) begin
                    fwd_hit[i]  = 1'b1;
                    fwd_data[i] = q_data[PW'((int'(head) + k) % QD)];
                end
            end
        end
    end

    // Capture forwarded data alongside the RAM read it replaces.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fwd_hit_r <= '0;
        else     fwd_hit_r <= fwd_hit & gnt;
    end

    // Forwarded payload register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < C; i++) fwd_data_r[i] <= fwd_data[i];
    end

    // Written flag or pending queued write.
    always_comb begin
        for (int i = 0; i < C; i++) begin
            rd_ready[i] = flags[rd_addr[i*S +: S]] | fwd_hit[i];
        end
    end
`else
    // Written flag of committed data only.
    always_comb begin
        for (int i = 0; i < C; i++) begin
            rd_ready[i] = flags[rd_addr[i*S +: S]];
        end
    end
`endif

    // Select the returning port per channel, else hold the last value.
    always_comb begin
        for (int i = 0; i < C; i++) begin
            rd_new[i] = src_b_r[i] ? q_rb : q_ra;
`ifdef WLMEM_FWD_EN
            if (fwd_hit_r[i]) rd_new[i] = fwd_data_r[i];
`endif
            rd_data[i*K +: K] = rv_r[i] ? rd_new[i] : held[i];
        end
    end

endmodule

// File: tb/tb_wire_label_mem_mp.sv
// tb_wire_label_mem_mp: directed vectors against a 4-channel, 4-deep build.
// Reads push expected {channel, data} when granted; a monitor pops on rd_valid.
module tb_wire_label_mem_mp;
    localparam int S  = 6;
    localparam int K  = 16;
    localparam int C  = 4;
    localparam int QD = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic [C-1:0]     wr_en = '0;
    logic [C*S-1:0]   wr_addr = '0;
    logic [C*K-1:0]   wr_data = '0;
    logic             wr_ready;
    logic [C-1:0]     rd_req = '0;
    logic [C*S-1:0]   rd_addr = '0;
    logic [C-1:0]     rd_gnt;
    logic [C-1:0]     rd_valid;
    logic [C*K-1:0]   rd_data;
    logic [C-1:0]     rd_ready;
    logic [$clog2(QD):0] q_level;
    logic             overflow;

    logic [K+1:0]     exp_q[$];
    int               n_vec = 0;
    int               n_err = 0;

    wire_label_mem_mp #(.S(S), .K(K), .C(C), .QD(QD)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .q_level(q_level), .overflow(overflow)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int ch, input logic [S-1:0] a, input logic [K-1:0] d);
        wr_en[ch] = 1'b1;
        wr_addr[ch*S +: S] = a;
        wr_data[ch*K +: K] = d;
    endtask

    task automatic push_exp(input int ch, input logic [K-1:0] d);
        exp_q.push_back({2'(ch), d});
    endtask

    // Issue a read and wait (bounded) for its grant; ends just after a rising edge.
    task automatic do_read(input int ch, input logic [S-1:0] a, input logic [K-1:0] d);
        bit got = 1'b0;
        rd_req[ch] = 1'b1;
        rd_addr[ch*S +: S] = a;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (rd_gnt[ch]) begin
                push_exp(ch, d);
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        rd_req[ch] = 1'b0;
        chk("rd_gnt_seen", 32'(got), 32'd1);
    endtask

    initial begin
        fork
            begin : monitor
                logic [K+1:0] e;
                forever begin
                    @(negedge clk);
                    for (int i = 0; i < C; i++) begin
                        if (rd_valid[i]) begin
                            if (exp_q.size() == 0) begin
                                n_vec++;
                                n_err++;
                                $display("FAIL rd_valid_unexpected: ch %0d got data %0h expected no response", i, rd_data[i*K +: K]);
                            end else begin
                                e = exp_q.pop_front();
                                chk("rd_channel", 32'(i), 32'(e[K+1:K]));
                                chk("rd_data", 32'(rd_data[i*K +: K]), 32'(e[K-1:0]));
                            end
                        end
                    end
                end
            end
        join_none

        // Reset state, with all read requests asserted
        rd_req = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_rd_gnt", 32'(rd_gnt), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data[31:0]), 32'd0);
        chk("rst_rd_data_hi", 32'(rd_data[63:32]), 32'd0);
        chk("rst_rd_ready", 32'(rd_ready), 32'd0);
        chk("rst_q_level", 32'(q_level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        tick();
        rst = 1'b0;
        rd_req = '0;

        // Single write, pop next cycle, flag the cycle after the pop
        set_wr(0, 6'd5, 16'h00A5);
        rd_addr[0*S +: S] = 6'd5;
        @(negedge clk);
        chk("a_rd_ready_pre", 32'(rd_ready[0]), 32'd0);
        chk("a_wr_ready", 32'(wr_ready), 32'd1);
        tick();
        wr_en = '0;
        @(negedge clk);
        chk("a_q_level_1", 32'(q_level), 32'd1);
`ifdef WLMEM_FWD_EN
        chk("a_rd_ready_queued", 32'(rd_ready[0]), 32'd1);
`else
        chk("a_rd_ready_queued", 32'(rd_ready[0]), 32'd0);
`endif
        tick();
        @(negedge clk);
        chk("a_q_level_0", 32'(q_level), 32'd0);
        chk("a_rd_ready_commit", 32'(rd_ready[0]), 32'd1);
        tick();
        do_read(0, 6'd5, 16'h00A5);

        // Same-address pair in one cycle: the higher channel is younger
        set_wr(0, 6'd9, 16'h0011);
        set_wr(1, 6'd9, 16'h0022);
        tick();
        wr_en = '0;
        rd_addr[1*S +: S] = 6'd9;
        @(negedge clk);
        chk("b_q_level_2", 32'(q_level), 32'd2);
        tick();
        @(negedge clk);
        chk("b_q_level_0", 32'(q_level), 32'd0);
        chk("b_rd_ready", 32'(rd_ready[1]), 32'd1);
        tick();
        do_read(1, 6'd9, 16'h0022);

        // Read colliding with a commit to the same address
        set_wr(0, 6'd2, 16'h1111);
        tick();
        wr_en = '0;
        tick();
        tick();
        set_wr(0, 6'd2, 16'h2222);
        tick();
        wr_en = '0;
`ifdef WLMEM_FWD_EN
        do_read(0, 6'd2, 16'h2222);
`else
        do_read(0, 6'd2, 16'h1111);
`endif

        // Fresh address: flag only after commit unless forwarding
        set_wr(1, 6'd3, 16'h0077);
        rd_addr[1*S +: S] = 6'd3;
        @(negedge clk);
        chk("c_rd_ready_pre", 32'(rd_ready[1]), 32'd0);
        tick();
        wr_en = '0;
        @(negedge clk);
`ifdef WLMEM_FWD_EN
        chk("c_rd_ready_queued", 32'(rd_ready[1]), 32'd1);
`else
        chk("c_rd_ready_queued", 32'(rd_ready[1]), 32'd0);
`endif
        tick();
        @(negedge clk);
        chk("c_rd_ready_commit", 32'(rd_ready[1]), 32'd1);
        tick();
        do_read(1, 6'd3, 16'h0077);

        // Round-robin: load 40..43, realign pointer with a channel 3 read
        for (int i = 0; i < C; i++) set_wr(i, 6'(40 + i), 16'(16'h4000 + i));
        @(negedge clk);
        chk("d_wr_ready", 32'(wr_ready), 32'd1);
        tick();
        wr_en = '0;
        tick();
        tick();
        do_read(3, 6'd43, 16'h4003);
        for (int i = 0; i < C; i++) rd_addr[i*S +: S] = 6'(40 + i);
        rd_req = 4'hF;
        for (int cyc = 0; cyc < 3; cyc++) begin
            logic [C-1:0] eg;
            eg = (cyc % 2 == 0) ? 4'b0011 : 4'b1100;
            @(negedge clk);
            chk("d_rr_gnt", 32'(rd_gnt), 32'(eg));
            for (int i = 0; i < C; i++) if (eg[i]) push_exp(i, 16'(16'h4000 + i));
            tick();
        end
        rd_req = '0;

        // Overflow: all channels write two cycles running
        for (int i = 0; i < C; i++) set_wr(i, 6'(16 + i), 16'(16'h1600 + i));
        @(negedge clk);
        chk("e_wr_ready_1", 32'(wr_ready), 32'd1);
        tick();
        for (int i = 0; i < C; i++) set_wr(i, 6'(20 + i), 16'(16'h2000 + i));
        @(negedge clk);
        chk("e_wr_ready_0", 32'(wr_ready), 32'd0);
        chk("e_q_level_4", 32'(q_level), 32'd4);
        chk("e_overflow_0", 32'(overflow), 32'd0);
        tick();
        wr_en = '0;
        @(negedge clk);
        chk("e_overflow_1", 32'(overflow), 32'd1);
        chk("e_q_level_2", 32'(q_level), 32'd2);
        tick();
        rd_addr[0*S +: S] = 6'd20;
        @(negedge clk);
        chk("e_q_level_0", 32'(q_level), 32'd0);
        chk("e_wr_ready_back", 32'(wr_ready), 32'd1);
        chk("e_overflow_sticky", 32'(overflow), 32'd1);
        chk("e_dropped_flag", 32'(rd_ready[0]), 32'd0);
        tick();
        do_read(2, 6'd18, 16'h1602);

        // Clear with three queued entries and a read granted in that cycle
        for (int i = 0; i < 3; i++) set_wr(i, 6'(24 + i), 16'(16'h2400 + i));
        tick();
        wr_en = '0;
        clr = 1'b1;
        rd_req[1] = 1'b1;
        rd_addr[1*S +: S] = 6'd18;
        @(negedge clk);
        chk("f_q_level_3", 32'(q_level), 32'd3);
        chk("f_clr_gnt", 32'(rd_gnt), 32'b0010);
        push_exp(1, 16'h1602);
        tick();
        clr = 1'b0;
        rd_req = '0;
        rd_addr[0*S +: S] = 6'd24;
        rd_addr[1*S +: S] = 6'd5;
        @(negedge clk);
        chk("f_q_level_0", 32'(q_level), 32'd0);
        chk("f_overflow_clr", 32'(overflow), 32'd0);
        chk("f_flag_discarded", 32'(rd_ready[0]), 32'd0);
        chk("f_flag_cleared", 32'(rd_ready[1]), 32'd0);
        tick();

        // Reset while a grant is pending
        rd_req[0] = 1'b1;
        rd_addr[0*S +: S] = 6'd16;
        @(negedge clk);
        chk("g_gnt_before_rst", 32'(rd_gnt), 32'b0001);
        #2 rst = 1'b1;
        #1 chk("g_gnt_in_rst", 32'(rd_gnt), 32'd0);
        tick();
        chk("g_rd_valid", 32'(rd_valid), 32'd0);
        chk("g_rd_data", 32'(rd_data[31:0]), 32'd0);
        chk("g_q_level", 32'(q_level), 32'd0);
        chk("g_wr_ready", 32'(wr_ready), 32'd1);
        chk("g_rd_ready", 32'(rd_ready), 32'd0);
        chk("g_overflow", 32'(overflow), 32'd0);
        rd_req = '0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
